// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: core (port 0) vs loader (port 1).
// Grants are combinational; read data returns one cycle after the read grant.
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RR_MODE    = 0,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // core port
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  stall0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    // loader port
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    // RAM side
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_writemem,
    output logic                  mem_readmem,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int unsigned WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]     r_wait1;
    logic                  r_owner_ldr;
    logic                  r_last_grant;
    logic                  r_tag_valid;
    logic                  r_tag_port;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic w_gnt0;
    logic w_gnt1;
    logic w_rd;
    logic w_rvalid0;
    logic w_rvalid1;

    // Arbitration: lock owner first, then starvation guard, then mode priority
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (r_owner_ldr) begin
                w_gnt1 = req1;
            end else if (req0 && req1) begin
                if (r_wait1 == WAIT_MAX) begin
                    w_gnt1 = 1'b1;
                end else if ((RR_MODE != 0) && !r_last_grant) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    assign w_rd = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;
    assign stall0 = req0 & ~w_gnt0;

    assign mem_addr     = w_gnt1 ? addr1  : (w_gnt0 ? addr0  : '0);
    assign mem_data     = w_gnt1 ? wdata1 : (w_gnt0 ? wdata0 : '0);
    assign mem_writemem = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign mem_readmem  = w_rd;

    // Read return: reset masks a tag that is still in flight
    assign w_rvalid0 = r_tag_valid & ~r_tag_port & ~reset;
    assign w_rvalid1 = r_tag_valid &  r_tag_port & ~reset;

    assign rvalid0 = w_rvalid0;
    assign rvalid1 = w_rvalid1;
    assign rdata0  = w_rvalid0 ? mem_q : r_rdata0;
    assign rdata1  = w_rvalid1 ? mem_q : r_rdata1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait1      <= '0;
            r_owner_ldr  <= 1'b0;
            r_last_grant <= 1'b1;
            r_tag_valid  <= 1'b0;
            r_tag_port   <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_gnt1 || !req1) begin
                r_wait1 <= '0;
            end else if (r_wait1 < WAIT_MAX) begin
                r_wait1 <= r_wait1 + WAIT_W'(1);
            end

            // Owner is taken on a locked grant and dropped after the first unlocked cycle
            if (w_gnt1 && lock1) begin
                r_owner_ldr <= 1'b1;
            end else if (r_owner_ldr && (!lock1 || !req1)) begin
                r_owner_ldr <= 1'b0;
            end

            if (w_gnt0 || w_gnt1) begin
                r_last_grant <= w_gnt1;
            end

            r_tag_valid <= w_rd;
            r_tag_port  <= w_gnt1;

            if (w_rvalid0) begin
                r_rdata0 <= mem_q;
            end
            if (w_rvalid1) begin
                r_rdata1 <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share the same stimulus;
// per-cycle grant/RAM expectations and read-return expectations are checked by a monitor.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [7:0] mem_q;

    logic       gnt0, stall0, rvalid0, gnt1, rvalid1, mem_writemem, mem_readmem;
    logic [7:0] rdata0, rdata1, mem_addr, mem_data;
    logic       gnt0_r, stall0_r, rvalid0_r, gnt1_r, rvalid1_r, mem_writemem_r, mem_readmem_r;
    logic [7:0] rdata0_r, rdata1_r, mem_addr_r, mem_data_r;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        string      nm;
        logic [1:0] gf;
        logic       chkr;
        logic [1:0] gr;
        logic       st0;
        logic       st_r;
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic       port;
        logic [7:0] data;
    } rd_t;

    exp_t q_exp[$];
    rd_t  q_rd[$];
    logic [7:0] h0 = '0;
    logic [7:0] h1 = '0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RR_MODE(0), .MAX_WAIT(4)) u_fix (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .stall0(stall0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_writemem(mem_writemem), .mem_readmem(mem_readmem), .mem_q(mem_q)
    );

    data_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RR_MODE(1), .MAX_WAIT(4)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_r), .stall0(stall0_r), .rvalid0(rvalid0_r), .rdata0(rdata0_r),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_r), .rvalid1(rvalid1_r), .rdata1(rdata1_r),
        .mem_addr(mem_addr_r), .mem_data(mem_data_r),
        .mem_writemem(mem_writemem_r), .mem_readmem(mem_readmem_r), .mem_q(mem_q)
    );

    // RAM model behind the fixed-priority instance
    always @(posedge clk) begin
        if (mem_writemem) mem[mem_addr] <= mem_data;
        if (mem_readmem)  mem_q <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the expected response
    task automatic step(input logic rs,
                        input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic l1, input logic [7:0] a1, input logic [7:0] d1,
                        input logic [1:0] gf, input logic chkr, input logic [1:0] gr,
                        input logic rdx, input logic [7:0] ed, input string nm);
        exp_t e;
        rd_t  r;
        @(posedge clk);
        #1;
        reset = rs; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        e.nm = nm; e.gf = gf; e.chkr = chkr; e.gr = gr;
        e.st0 = r0 & ~gf[0];
        e.st_r = r0 & ~gr[0];
        if (gf[1]) begin
            e.wr = w1; e.rd = ~w1; e.addr = a1; e.data = d1;
        end else if (gf[0]) begin
            e.wr = w0; e.rd = ~w0; e.addr = a0; e.data = d0;
        end else begin
            e.wr = 1'b0; e.rd = 1'b0; e.addr = 8'h00; e.data = 8'h00;
        end
        q_exp.push_back(e);
        if (rdx) begin
            r.port = gf[1];
            r.data = ed;
            q_rd.push_back(r);
        end
    endtask

    task automatic idle(input string nm);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00,
             2'b00, 1'b1, 2'b00, 1'b0, 8'h00, nm);
    endtask

    // Monitor: mid-cycle compare of grants/RAM strobes and in-order read returns
    always @(negedge clk) begin
        exp_t e;
        rd_t  r;
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk({e.nm, ".gnt"},   32'({gnt1, gnt0}), 32'(e.gf));
            chk({e.nm, ".stall"}, 32'(stall0), 32'(e.st0));
            chk({e.nm, ".wr"},    32'(mem_writemem), 32'(e.wr));
            chk({e.nm, ".rd"},    32'(mem_readmem), 32'(e.rd));
            chk({e.nm, ".addr"},  32'(mem_addr), 32'(e.addr));
            chk({e.nm, ".data"},  32'(mem_data), 32'(e.data));
            if (e.chkr) begin
                chk({e.nm, ".rr_gnt"},   32'({gnt1_r, gnt0_r}), 32'(e.gr));
                chk({e.nm, ".rr_stall"}, 32'(stall0_r), 32'(e.st_r));
            end
        end
        if (rvalid0 || rvalid1) begin
            if (q_rd.size() == 0) begin
                chk("unexpected_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
            end else begin
                r = q_rd.pop_front();
                chk("rvalid_port", 32'({rvalid1, rvalid0}), r.port ? 32'd2 : 32'd1);
                chk("rdata", r.port ? 32'(rdata1) : 32'(rdata0), 32'(r.data));
                if (r.port) h1 = r.data;
                else        h0 = r.data;
            end
        end
        if (!rvalid0) chk("rdata0_hold", 32'(rdata0), 32'(h0));
        if (!rvalid1) chk("rdata1_hold", 32'(rdata1), 32'(h1));
        if (reset) begin
            h0 = 8'h00;
            h1 = 8'h00;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // reset forces grants low, then idle with stray addresses
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, "rst_force");
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, "rst_idle");
        step(1'b0, 1'b0, 1'b0, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 8'h77, 8'h88, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, "idle");

        // both ports writing continuously: fixed 0,0,0,0,1 pattern vs round-robin alternation
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b1, 8'h20, 8'h11, 1'b1, 1'b1, 1'b0, 8'h21, 8'h22,
                 (k == 4 || k == 9) ? 2'b10 : 2'b01, 1'b1, (k % 2 == 1) ? 2'b10 : 2'b01,
                 1'b0, 8'h00, "both");
        end
        idle("gap0");

        // loader write then core read of the same address
        step(1'b0, 1'b0, 1'b0, 8'h10, 8'h77, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA5, 2'b10, 1'b1, 2'b10, 1'b0, 8'h00, "ldr_wr");
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 1'b1, 2'b01, 1'b1, 8'hA5, "core_rd");
        idle("rd_ret");
        idle("hold");

        // back-to-back reads from different ports
        step(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 1'b1, 2'b01, 1'b1, 8'h11, "b2b_c");
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 2'b10, 1'b1, 2'b10, 1'b1, 8'h22, "b2b_l");
        idle("b2b_ret");
        idle("gap1");

        // lock without grant is ignored; starvation gives the grant, then lock holds it for 3 writes
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 1'b1, 8'h30, 8'h33, 1'b1, 1'b1, 1'b1, 8'h40, 8'h44, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, "lk_wait");
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 1'b1, 8'h30, 8'h33, 1'b1, 1'b1, 1'b1, 8'h40, 8'h44, 2'b10, 1'b0, 2'b00, 1'b0, 8'h00, "lk_own");
        step(1'b0, 1'b1, 1'b1, 8'h30, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, "lk_rel");
        step(1'b0, 1'b1, 1'b1, 8'h30, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, "lk_after");
        idle("gap2");

        // core read in flight when reset hits: no rvalid, port 0 first afterwards
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, "pre_rst_rd");
        step(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, "rst_mid");
        step(1'b0, 1'b1, 1'b1, 8'h50, 8'h55, 1'b1, 1'b1, 1'b0, 8'h51, 8'h56, 2'b01, 1'b1, 2'b01, 1'b0, 8'h00, "post_rst");
        idle("end_idle");
        idle("end_idle2");

        repeat (2) @(posedge clk);
        #2;
        chk("rd_queue_empty", 32'(q_rd.size()), 32'd0);
        chk("exp_queue_empty", 32'(q_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, RAM address width; DATA_WIDTH, default 8, data width; RR_MODE, default 0, 0 = fixed core priority, 1 = round-robin; MAX_WAIT, default 4, loader starvation limit in cycles (1..15).
REQ-002 Ports SHALL be as follows, each as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- req0, we0, in, 1 each, core request and write-enable.
- addr0, in, ADDR_WIDTH, core address.
- wdata0, in, DATA_WIDTH, core write data.
- gnt0, out, 1, core granted this cycle.
- stall0, out, 1, req0 & ~gnt0.
- rvalid0, out, 1, core read data valid.
- rdata0, out, DATA_WIDTH, core read data.
- req1, we1, lock1, in, 1 each, loader request, write-enable and burst lock.
- addr1, in, ADDR_WIDTH, loader address.
- wdata1, in, DATA_WIDTH, loader write data.
- gnt1, rvalid1, out, 1 each, loader grant and read data valid.
- rdata1, out, DATA_WIDTH, loader read data.
- mem_addr, out, ADDR_WIDTH, RAM address.
- mem_data, out, DATA_WIDTH, RAM write data.
- mem_writemem, mem_readmem, out, 1 each, RAM write and read strobes.
- mem_q, in, DATA_WIDTH, RAM read data, valid one cycle after the read strobe.

Function
REQ-003 At most one of gnt0/gnt1 SHALL be high in any cycle; a grant SHALL only be given to a port whose req is high in that cycle.
REQ-004 Grant SHALL be combinational from the current requests and registered arbiter state; a granted access completes in its grant cycle.
REQ-005 RAM outputs SHALL follow the granted port: mem_addr = addrN; mem_data = wdataN; mem_writemem = weN; mem_readmem = ~weN.
REQ-006 With no grant, mem_writemem and mem_readmem SHALL be 0, and mem_addr and mem_data SHALL be 0.
REQ-007 Fixed mode (RR_MODE = 0): if both ports request, port 0 wins, except under REQ-009 and REQ-010.
REQ-008 Round-robin mode (RR_MODE = 1): if both ports request, the port not granted last SHALL win.
- last_grant register updates on every grant.
- Single requester always wins.
REQ-009 Starvation guard: wait1 counter SHALL increment each cycle req1 is high and gnt1 is low.
- Counter saturates at MAX_WAIT.
- Counter clears on gnt1 or when req1 is low.
- When wait1 = MAX_WAIT, port 1 SHALL win over port 0 in both modes.
REQ-010 Lock: a cycle with gnt1 & lock1 high SHALL set the owner register to loader.
- While owner = loader, gnt0 = 0 regardless of req0.
- Owner releases after the first cycle with lock1 low or req1 low.
- lock1 without gnt1 has no effect.
REQ-011 Read return: a granted read SHALL set a one-cycle pipeline tag (valid, port).
- Next cycle, rvalidN = 1 for the tagged port only, with rdataN = mem_q.
- Writes produce no rvalid.
REQ-012 rdataN SHALL hold its last value when rvalidN = 0.
REQ-013 Back-to-back reads by different ports on consecutive cycles SHALL each return exactly one rvalid on the correct port, in issue order.

Reset
REQ-014 While reset is high at a clock edge, the following SHALL clear:
- gnt0, gnt1, mem_writemem, mem_readmem = 0.
- rvalid0, rvalid1 = 0; rdata0, rdata1 = 0.
- wait1 = 0; owner = none; last_grant = port 1, so port 0 wins first in round-robin.
REQ-015 While reset is high, grants SHALL be forced to 0 combinationally.
REQ-016 Reset asserted mid-lock or with a read in flight SHALL drop the lock and the pending rvalid; no rvalid is issued in the cycle after reset.

Verification
REQ-017 Fixed mode, req0 = req1 = 1 continuously, MAX_WAIT = 4 -> gnt0 for 4 cycles, gnt1 on cycle 5, wait1 returns to 0, pattern repeats.
REQ-018 Round-robin mode, both requesting from reset -> grants alternate 0,1,0,1; stall0 = 1 exactly on the port-1 cycles.
REQ-019 Loader writes 0xA5 to address 0x10 while req0 is low; next cycle core reads 0x10 -> mem_writemem = 1 then mem_readmem = 1; rvalid0 = 1 with rdata0 = 0xA5 one cycle after the read grant.
REQ-020 Loader holds lock1 = 1 for 3 granted writes while req0 = 1 -> gnt0 = 0 for those 3 cycles, gnt0 = 1 in the cycle after lock1 falls.
REQ-021 Core read granted, reset asserted the next edge -> rvalid0 stays 0, all outputs at reset values, first post-reset grant goes to port 0.
REQ-022 Idle (req0 = req1 = 0) -> no strobes, mem_addr = 0, no rvalid, wait1 = 0.
